// File: rtl/counter_ctrl_pkg.sv
// Shared opcode/state encodings and register reset defaults for counter_ctrl.
package counter_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_NOP        = 3'd0,
        OP_LOAD       = 3'd1,
        OP_SET_CMP    = 3'd2,
        OP_SET_PRESC  = 3'd3,
        OP_START_UP   = 3'd4,
        OP_START_DOWN = 3'd5,
        OP_STOP       = 3'd6,
        OP_ONESHOT    = 3'd7
    } ctrl_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } ctrl_state_e;

    localparam logic [7:0] CMP_RST   = 8'hFF;
    localparam logic [7:0] PRESC_RST = 8'h00;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: while enabled, counts 0..presc and emits a tick on the terminal count.
module tick_gen #(
    parameter int unsigned PRESC_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               restart,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);

    logic [PRESC_W-1:0] pc_q;
    logic [PRESC_W-1:0] pc_d;

    // The restart cycle only clears the count, so the first tick after a
    // restart lands presc+1 enabled cycles later.
    always_comb begin
        tick = en && !restart && (pc_q == presc);
        pc_d = pc_q;
        if (en) begin
            pc_d = (restart || tick) ? '0 : pc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/counter_ctrl.sv
// Command sequencer for the tt_um_top counter datapath: decodes opcodes into
// load strobes, prescaled count ticks, direction and compare/one-shot status.
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned PRESC_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [WIDTH-1:0] cnt_val,
    output logic             cnt_load,
    output logic [WIDTH-1:0] cnt_load_val,
    output logic             cnt_tick,
    output logic             cnt_up,
    output logic             match,
    output logic             done,
    output logic [1:0]       state
);

    ctrl_state_e        state_q, state_d;
    ctrl_op_e           op;
    logic               oneshot_q, oneshot_d;
    logic               resume_q, resume_d;
    logic               up_q, up_d;
    logic [WIDTH-1:0]   load_val_q, load_val_d;
    logic [WIDTH-1:0]   cmp_q, cmp_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               done_q, done_d;
    logic               restart_q, restart_d;
    logic               tick_q;
    logic               cmd_accept;
    logic               run_en;

    assign op         = ctrl_op_e'(cmd_op);
    assign cmd_ready  = ena && (state_q != ST_LOAD);
    assign cmd_accept = cmd_valid && cmd_ready;
    assign match      = tick_q && (cnt_val == cmp_q);
    // A one-shot hit must not let the prescaler issue a tick in the match cycle.
    assign run_en     = ena && (state_q == ST_RUN) && !(oneshot_q && match);

    assign cnt_load     = (state_q == ST_LOAD);
    assign cnt_load_val = load_val_q;
    assign cnt_up       = up_q;
    assign done         = done_q;
    assign state        = state_q;

    tick_gen #(
        .PRESC_W (PRESC_W)
    ) u_tick_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (run_en),
        .restart (restart_q),
        .presc   (presc_q),
        .tick    (cnt_tick)
    );

    always_comb begin
        state_d    = state_q;
        oneshot_d  = oneshot_q;
        resume_d   = resume_q;
        up_d       = up_q;
        load_val_d = load_val_q;
        cmp_d      = cmp_q;
        presc_d    = presc_q;
        done_d     = done_q;
        restart_d  = restart_q;
        if (ena) begin
            restart_d = 1'b0;
            if ((state_q == ST_RUN) && oneshot_q && match) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
            // An accepted command overrides the one-shot completion above.
            if (cmd_accept) begin
                if (op != OP_NOP) begin
                    done_d = 1'b0;
                end
                case (op)
                    OP_LOAD: begin
                        state_d    = ST_LOAD;
                        load_val_d = cmd_data;
                        resume_d   = (state_q == ST_RUN);
                    end
                    OP_SET_CMP:   cmp_d   = cmd_data;
                    OP_SET_PRESC: presc_d = cmd_data[PRESC_W-1:0];
                    OP_START_UP, OP_START_DOWN: begin
                        state_d   = ST_RUN;
                        up_d      = (op == OP_START_UP);
                        oneshot_d = 1'b0;
                        restart_d = 1'b1;
                    end
                    OP_STOP: state_d = ST_IDLE;
                    OP_ONESHOT: begin
                        state_d   = ST_RUN;
                        oneshot_d = 1'b1;
                        restart_d = 1'b1;
                    end
                    default: ;
                endcase
            end else if (state_q == ST_LOAD) begin
                state_d   = resume_q ? ST_RUN : ST_IDLE;
                restart_d = resume_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            oneshot_q  <= 1'b0;
            resume_q   <= 1'b0;
            up_q       <= 1'b1;
            load_val_q <= '0;
            cmp_q      <= WIDTH'(CMP_RST);
            presc_q    <= PRESC_W'(PRESC_RST);
            done_q     <= 1'b0;
            restart_q  <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            oneshot_q  <= oneshot_d;
            resume_q   <= resume_d;
            up_q       <= up_d;
            load_val_q <= load_val_d;
            cmp_q      <= cmp_d;
            presc_q    <= presc_d;
            done_q     <= done_d;
            restart_q  <= restart_d;
            tick_q     <= cnt_tick;
        end
    end

endmodule

// File: doc/counter_ctrl.md
# counter_ctrl

Command-driven sequencer for the 8-bit counter datapath in `tt_um_top`. It accepts opcodes over a valid/ready port fed from the pin-decoding logic. From those it produces the counter's load strobe and load value, the count-enable ticks and the direction. A programmable prescaler sets the tick rate, and a compare register detects a match and supports one-shot runs. The counter register itself stays outside this block; this block only sequences it.

## Interface
- `WIDTH`, 8, counter / data width
- `PRESC_W`, 4, prescaler field width
- `clk`  in  1  design clock
- `rst_n`  in  1  reset; asynchronous, active-low
- `ena`  in  1  design-selected enable; low freezes all sequencing
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready`
- `cmd_op`  in  3  opcode
- `cmd_data`  in  WIDTH  opcode operand
- `cnt_val`  in  WIDTH  current counter value, registered in the datapath
- `cnt_load`  out  1  one-cycle load strobe
- `cnt_load_val`  out  WIDTH  value to load, valid with `cnt_load`
- `cnt_tick`  out  1  one-cycle count enable
- `cnt_up`  out  1  direction: 1 = increment, 0 = decrement
- `match`  out  1  one-cycle pulse on compare hit
- `done`  out  1  sticky; one-shot finished
- `state`  out  2  FSM state, for debug / `uo_out`

## Operation
- Opcodes:
  - 0 NOP
  - 1 LOAD: operand → counter
  - 2 SET_CMP: operand → compare register
  - 3 SET_PRESC: `cmd_data[PRESC_W-1:0]` → prescaler
  - 4 START_UP
  - 5 START_DOWN
  - 6 STOP
  - 7 ONESHOT: run with the current `cnt_up`; stop on match
- States:
  - IDLE=0, LOAD=1, RUN=2, DONE=3
  - A one-shot flag qualifies RUN.
- Transitions:
  - IDLE/RUN/DONE + LOAD → LOAD.
  - LOAD → next cycle returns to RUN if the block was running before the LOAD, else IDLE. The one-shot flag is kept.
  - START_UP/START_DOWN → RUN, set `cnt_up`, clear the one-shot flag.
  - ONESHOT → RUN, set the one-shot flag.
  - STOP → IDLE from any state.
  - RUN with the one-shot flag set, on match → DONE.
  - SET_CMP, SET_PRESC and NOP never change state.
- Every accepted command except NOP clears `done`.
- Prescaler:
  - A counter `pc` counts 0..presc while in RUN.
  - `cnt_tick` is asserted in the cycle where `pc == presc`; `pc` wraps to 0 on that cycle.
  - `pc` is reset to 0 on every entry to RUN.
  - presc=0 gives a tick every cycle.
- Compare:
  - In the cycle after a `cnt_tick`, if `cnt_val == cmp`, pulse `match`.
  - A LOAD whose value equals `cmp` does not match.
- Counter wrap-around is the datapath's behaviour. The controller keeps ticking through it.
- `cnt_load_val` holds the last LOAD operand.
- `cnt_up` holds its value through IDLE and DONE.

## Timing
- Reset values:
  - state IDLE; `cmd_ready` 0 until `ena`
  - `cnt_load`, `cnt_tick`, `match`, `done` all 0
  - `cnt_up` 1; `cnt_load_val` 0; cmp 0xFF; presc 0; `pc` 0
- `cmd_ready = ena && state != LOAD`; it is combinational from state and `ena`.
- Command latency:
  - An op accepted at edge N takes effect at edge N+1: state, `cnt_load` or registers update.
  - `cnt_load` is high for exactly one cycle, while in LOAD.
- After START accepted at edge N: the first `cnt_tick` is in the cycle after edge N+1+presc.
- `match` is high 1 cycle after the tick edge. In one-shot mode, DONE is entered on that same edge and no further ticks are issued.
- `ena` low:
  - `cnt_tick` is forced to 0, `pc` holds and no commands are accepted.
  - State, registers and `done` hold.
  - Resuming continues from the held `pc`.
- Simultaneous events:
  - A command accepted in a tick cycle: the tick is still issued, and the command applies next cycle.
  - STOP in a match cycle: `match` still pulses, state goes IDLE, `done` stays 0.
- `rst_n` asserted mid-run: all outputs go to their reset values immediately, without waiting for a clock edge.

## Structure
- Package `counter_ctrl_pkg` holds:
  - `ctrl_op_e` for the opcodes
  - `ctrl_state_e` for the state encodings
  - default localparams for cmp (0xFF) and presc (0)
- Sub-module `tick_gen` (prescaler):
  - Inputs: `clk`, `rst_n`, `en`, `restart`, `presc`.
  - Output: `tick`.
- The FSM, the compare logic and the command decode stay in `counter_ctrl`.

## Test plan
- Reset → all outputs at reset values; after `ena`=1, `cmd_ready`=1.
- LOAD 0x10, then START_UP with presc=0 → `cnt_load` high 1 cycle with `cnt_load_val`=0x10; then `cnt_tick` every cycle and `cnt_up`=1.
- SET_PRESC 3, then START_DOWN → `cnt_tick` every 4th cycle, first tick 4 cycles after accept; `cnt_up`=0.
- SET_CMP 0x05, LOAD 0x00, ONESHOT with presc 0 → exactly 5 ticks; `match` 1 cycle after the 5th; state DONE and `done`=1; no further ticks.
- LOAD issued mid-RUN → one LOAD cycle with `cmd_ready`=0 and no tick; RUN resumes with the prescaler restarted.
- `ena` dropped for 3 cycles mid-RUN (presc=2) → no ticks and `cmd_valid` ignored; tick spacing resumes from the held count. Async `rst_n` pulse mid-run → outputs reset with no clock edge.
